// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared types for the instruction-trace capture unit.
//   trace_state_e : capture FSM encoding, also exported on state_o
//   trace_entry_t : one trace record at the default widths (pc, instr, flags),
//                   in the same bit order the buffer stores it
//   FWD_A..REG_WRITE : bit positions inside the packed hazard flag vector
package riscv_trace_pkg;

  localparam int TR_DW    = 32;
  localparam int TR_FLAGW = 8;

  localparam int FWD_A     = 0;
  localparam int FWD_B     = 1;
  localparam int STALL_FD  = 2;
  localparam int STALL_MW  = 3;
  localparam int REG_WRITE = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TR_DW-1:0]    pc;
    logic [TR_DW-1:0]    instr;
    logic [TR_FLAGW-1:0] flags;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x WIDTH trace storage.
//   clk_i            : write clock
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i/rdata_o  : asynchronous read port
// The array has no reset; validity of entries is tracked by the caller's count.
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 72,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTRW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTRW-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: on-chip instruction trace for the 3-stage core.
//   Capture : valid_i, pc_i, instr_i, flags_i tapped from decode each cycle
//   Control : arm_i, abort_i, trig_pc_i, trig_en_i, trig_force_i, post_cnt_i
//   Readout : rd_valid_o/rd_ready_i handshake, rd_pc_o, rd_instr_o, rd_flags_o
//             (oldest entry first)
//   Status  : state_o, count_o, wrapped_o, done_o (pulse after last drain)
// Entries go into a circular buffer while ARMED; a trigger (PC match or
// forced) opens a post-trigger window of post_cnt_i further valid entries,
// then the buffer is frozen and drained.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int FLAGW = 8,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [DW-1:0]    pc_i,
  input  logic [DW-1:0]    instr_i,
  input  logic [FLAGW-1:0] flags_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [DW-1:0]    trig_pc_i,
  input  logic             trig_en_i,
  input  logic             trig_force_i,
  input  logic [PTRW-1:0]  post_cnt_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [DW-1:0]    rd_pc_o,
  output logic [DW-1:0]    rd_instr_o,
  output logic [FLAGW-1:0] rd_flags_o,
  output logic [1:0]       state_o,
  output logic [PTRW:0]    count_o,
  output logic             wrapped_o,
  output logic             done_o
);

  localparam int EW   = 2*DW + FLAGW;
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  trace_state_e    state_q, state_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PTRW-1:0] post_q, post_d;
  logic            wrapped_q, wrapped_d;
  logic            done_q, done_d;

  logic            cap_en;
  logic            rd_valid;
  logic            rd_fire;
  logic            trig;
  logic [PTRW-1:0] rd_ptr;
  logic [EW-1:0]   wr_word;
  logic [EW-1:0]   rd_word;

  // Trigger only counts while ARMED; a forced trigger needs no valid beat.
  assign trig = (state_q == ST_ARMED) &
                (trig_force_i | (trig_en_i & valid_i & (pc_i == trig_pc_i)));

  assign rd_fire = rd_valid & rd_ready_i;

  // Oldest entry sits count slots behind the write pointer; when full the
  // low bits of count are zero and this lands on wr_ptr itself.
  assign rd_ptr  = wr_ptr_q - cnt_q[PTRW-1:0];
  assign wr_word = {pc_i, instr_i, flags_i};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (cap_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr),
    .rdata_o (rd_word)
  );

  // State register and datapath flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      post_q    <= post_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (arm_i) state_d = ST_ARMED;
        ST_ARMED:   if (trig) state_d = (post_q == '0) ? ST_READOUT : ST_POST;
        ST_POST:    if (valid_i && post_q == PTRW'(1)) state_d = ST_READOUT;
        ST_READOUT: if (cnt_q == '0 || (rd_fire && cnt_q == CNTW'(1)))
                      state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // State-decoded controls.
  always_comb begin
    cap_en   = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      ST_ARMED, ST_POST: cap_en   = valid_i & ~abort_i;
      ST_READOUT:        rd_valid = (cnt_q != '0);
      default: ;
    endcase
  end

  // Pointer / count / post-window / status updates.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    post_d    = post_q;
    wrapped_d = wrapped_q;
    done_d    = 1'b0;
    if (abort_i) begin
      wr_ptr_d  = '0;
      cnt_d     = '0;
      wrapped_d = 1'b0;
    end else begin
      if (state_q == ST_IDLE && arm_i) begin
        post_d    = post_cnt_i;
        wr_ptr_d  = '0;
        cnt_d     = '0;
        wrapped_d = 1'b0;
      end
      if (cap_en) begin
        wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (cnt_q == FULL) wrapped_d = 1'b1;   // overwrote the oldest entry
        else               cnt_d     = cnt_q + CNTW'(1);
      end
      if (state_q == ST_POST && valid_i) post_d = post_q - PTRW'(1);
      if (rd_fire) cnt_d = cnt_q - CNTW'(1);
      // Leaving READOUT without abort means the buffer is empty.
      if (state_q == ST_READOUT && state_d == ST_IDLE) done_d = 1'b1;
    end
  end

  // Read data is forced to zero when no entry is presented.
  assign rd_valid_o = rd_valid;
  assign rd_pc_o    = rd_valid ? rd_word[EW-1 -: DW]       : '0;
  assign rd_instr_o = rd_valid ? rd_word[FLAGW +: DW]      : '0;
  assign rd_flags_o = rd_valid ? rd_word[FLAGW-1:0]        : '0;
  assign state_o    = state_q;
  assign count_o    = cnt_q;
  assign wrapped_o  = wrapped_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: randomized capture sessions
// against a queue-based reference; readout entries checked by a monitor.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DW = 32, FLAGW = 8, DEPTH = 16, PTRW = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [DW-1:0]    pc_i, instr_i, trig_pc_i;
  logic [FLAGW-1:0] flags_i;
  logic             arm_i, abort_i, trig_en_i, trig_force_i, rd_ready_i;
  logic [PTRW-1:0]  post_cnt_i;
  logic             rd_valid_o, wrapped_o, done_o;
  logic [DW-1:0]    rd_pc_o, rd_instr_o;
  logic [FLAGW-1:0] rd_flags_o;
  logic [1:0]       state_o;
  logic [PTRW:0]    count_o;

  always #5 clk_i = ~clk_i;

  riscv_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .FLAGW(FLAGW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instr_i(instr_i), .flags_i(flags_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_pc_i(trig_pc_i), .trig_en_i(trig_en_i), .trig_force_i(trig_force_i),
    .post_cnt_i(post_cnt_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
    .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .rd_flags_o(rd_flags_o),
    .state_o(state_o), .count_o(count_o), .wrapped_o(wrapped_o), .done_o(done_o)
  );

  int checks = 0, failures = 0;
  trace_entry_t exp_q[$];   // scoreboard: entries expected on readout
  trace_entry_t cap[$];     // reference: last DEPTH captured entries
  int  m_mode = 0;          // 0 idle, 1 armed, 2 post window, 3 readout
  int  m_post = 0;
  bit  m_wrapped = 0;
  int  done_cnt = 0;
  bit  first_seen = 0;
  logic [31:0] first_pc = '0;

  // session stimulus settings
  int vpat = 0, cyc = 0, trig_mode = 0, trig_idx = 0;
  logic [31:0] nxt_pc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input trace_entry_t e);
    cap.push_back(e);
    if (cap.size() > DEPTH) begin
      void'(cap.pop_front());
      m_wrapped = 1;
    end
  endtask

  // Reference behaviour at a clock edge, from the currently driven inputs.
  task automatic model_edge();
    trace_entry_t e;
    bit trig;
    e = '{pc: pc_i, instr: instr_i, flags: flags_i};
    if (rst_i || abort_i) begin
      m_mode = 0; cap.delete(); m_wrapped = 0;
    end else begin
      case (m_mode)
        0: if (arm_i) begin
             m_mode = 1; m_post = int'(post_cnt_i); cap.delete(); m_wrapped = 0;
           end
        1: begin
             trig = trig_force_i || (trig_en_i && valid_i && pc_i == trig_pc_i);
             if (valid_i) push(e);
             if (trig) m_mode = (m_post == 0) ? 3 : 2;
           end
        2: if (valid_i) begin
             push(e); m_post--;
             if (m_post == 0) m_mode = 3;
           end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic arm(input int post, input logic [31:0] spc, input int tmode,
                     input int tidx, input int vp);
    post_cnt_i = PTRW'(post); arm_i = 1;
    trig_mode = tmode; trig_idx = tidx; vpat = vp; nxt_pc = spc; cyc = 0;
    trig_en_i = (tmode == 0);
    trig_pc_i = spc + 32'(4 * tidx);
    step();
    arm_i = 0;
  endtask

  task automatic cap_cycle();
    bit v;
    case (vpat)
      0: v = 1;
      1: v = (cyc % 2 == 1);
      3: v = (cyc < trig_idx);
      default: v = ($urandom_range(0, 2) != 0);
    endcase
    valid_i = v;
    pc_i    = v ? nxt_pc : $urandom;
    instr_i = $urandom;
    flags_i = FLAGW'($urandom);
    flags_i[REG_WRITE] = v;
    if (trig_mode == 1) trig_force_i = (cyc == trig_idx);
    else                trig_force_i = (m_mode == 2) && ($urandom_range(0, 3) == 0);
    step();
    if (v) nxt_pc += 4;
    cyc++;
  endtask

  task automatic cap_run(input int stop_mode);
    int n = 0;
    while (m_mode != stop_mode && n < 400) begin cap_cycle(); n++; end
    valid_i = 0; trig_force_i = 0;
    if (m_mode != stop_mode) begin
      checks++; failures++;
      $display("FAIL cap_timeout state=%0d expected %0d", state_o, stop_mode);
    end
  endtask

  task automatic entry_check();
    chk("ro_state", 64'(state_o), 64'd3);
    chk("ro_count", 64'(count_o), 64'(cap.size()));
    chk("ro_wrapped", 64'(wrapped_o), 64'(m_wrapped));
    foreach (cap[i]) exp_q.push_back(cap[i]);
    first_seen = 0;
  endtask

  task automatic drain(input int rpat);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (state_o == 2'd3 && n < 300) begin
      case (rpat)
        0:       rd_ready_i = 1'($urandom_range(0, 1));
        1:       rd_ready_i = (n % 4 == 0) || (n % 4 == 3);
        default: rd_ready_i = 1;
      endcase
      step(); n++;
    end
    rd_ready_i = 0;
    step();
    chk("drain_idle", 64'(state_o), 64'd0);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("done_pulse_len", 64'(done_o), 64'd0);
    chk("drain_count", 64'(count_o), 64'd0);
    m_mode = 0;
  endtask

  // Monitor: pops the scoreboard on every readout handshake.
  initial begin : monitor
    trace_entry_t e;
    bit p_valid, p_ready, p_abort;
    logic [31:0] p_pc;
    p_valid = 0; p_ready = 0; p_abort = 0; p_pc = '0;
    forever begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
      if (p_valid && !p_ready && !p_abort && !rst_i) begin
        chk("hold_valid", 64'(rd_valid_o), 64'd1);
        chk("hold_pc", 64'(rd_pc_o), 64'(p_pc));
      end
      if (rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_entry pc=%0h expected no entry", rd_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("rd_pc", 64'(rd_pc_o), 64'(e.pc));
          chk("rd_instr", 64'(rd_instr_o), 64'(e.instr));
          chk("rd_flags", 64'(rd_flags_o), 64'(e.flags));
          if (!first_seen) begin first_seen = 1; first_pc = rd_pc_o; end
        end
      end
      p_valid = rd_valid_o; p_ready = rd_ready_i; p_abort = abort_i; p_pc = rd_pc_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int d0;
    rst_i = 1; valid_i = 0; pc_i = '0; instr_i = '0; flags_i = '0; arm_i = 0;
    abort_i = 0; trig_pc_i = '0; trig_en_i = 0; trig_force_i = 0;
    post_cnt_i = '0; rd_ready_i = 0;
    #1;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_wrapped", 64'(wrapped_o), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    step(); step();
    rst_i = 0;
    step();

    // PC-match trigger at 0x20, two-entry post window, valid every cycle.
    arm(2, 32'h0, 0, 8, 0);
    cap_run(3);
    entry_check();
    chk("t1_count11", 64'(count_o), 64'd11);
    drain(2);
    chk("t1_first_pc", 64'(first_pc), 64'h0);

    // 30 valid entries then a forced trigger: buffer wrapped, oldest kept is #15.
    arm(0, 32'h0, 1, 30, 3);
    cap_run(3);
    entry_check();
    chk("t2_count_full", 64'(count_o), 64'd16);
    chk("t2_wrapped", 64'(wrapped_o), 64'd1);
    drain(1);
    chk("t2_first_pc", 64'(first_pc), 64'h38);

    // Post window with valid on alternate cycles; ready toggling 1,0,0,1.
    arm(5, 32'h1000, 0, 3, 1);
    cap_run(3);
    entry_check();
    drain(1);

    // Forced trigger with no captured entry: empty readout still pulses done.
    arm(0, 32'h200, 1, 0, 1);
    cap_run(3);
    entry_check();
    drain(0);

    // Abort mid-POST.
    arm(10, 32'h400, 0, 2, 0);
    cap_run(2);
    d0 = done_cnt;
    abort_i = 1; step(); abort_i = 0;
    chk("abort_post_state", 64'(state_o), 64'd0);
    chk("abort_post_count", 64'(count_o), 64'd0);
    chk("abort_post_rdv", 64'(rd_valid_o), 64'd0);
    step(); step();
    chk("abort_post_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort mid-READOUT after two entries drained.
    arm(3, 32'h800, 1, 6, 0);
    cap_run(3);
    entry_check();
    rd_ready_i = 1; step(); step();
    rd_ready_i = 0;
    d0 = done_cnt;
    abort_i = 1; step(); abort_i = 0;
    exp_q.delete();
    chk("abort_ro_state", 64'(state_o), 64'd0);
    chk("abort_ro_count", 64'(count_o), 64'd0);
    chk("abort_ro_rdv", 64'(rd_valid_o), 64'd0);
    step(); step();
    chk("abort_ro_nodone", 64'(done_cnt - d0), 64'd0);

    // Reset asserted mid-ARMED (buffer already wrapped): outputs clear at once.
    arm(4, 32'h0, 0, 100, 0);
    repeat (20) cap_cycle();
    valid_i = 0;
    rst_i = 1; #1;
    chk("rst_mid_state", 64'(state_o), 64'd0);
    chk("rst_mid_count", 64'(count_o), 64'd0);
    chk("rst_mid_wrapped", 64'(wrapped_o), 64'd0);
    chk("rst_mid_rdv", 64'(rd_valid_o), 64'd0);
    chk("rst_mid_rdpc", 64'(rd_pc_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    step();
    rst_i = 0;
    step();

    // arm_i during READOUT ignored; trig_force_i in IDLE ignored.
    arm(2, 32'h3000, 1, 4, 0);
    cap_run(3);
    entry_check();
    post_cnt_i = 4'd9; arm_i = 1; step(); arm_i = 0;
    chk("arm_in_ro_state", 64'(state_o), 64'd3);
    chk("arm_in_ro_count", 64'(count_o), 64'(cap.size()));
    drain(0);
    trig_force_i = 1; step(); trig_force_i = 0;
    chk("force_idle_state", 64'(state_o), 64'd0);
    chk("force_idle_count", 64'(count_o), 64'd0);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      arm($urandom_range(0, 15), 32'($urandom_range(0, 4096)) * 4,
          $urandom_range(0, 1), $urandom_range(0, 40), $urandom_range(0, 2));
      cap_run(3);
      entry_check();
      drain($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
Synthesisable, parametrised instruction-trace capture unit for the 3-stage pipelined core; replaces bench-only per-cycle printing with on-chip logging.
Taps the decode-stage PC/instruction plus hazard flags (forward_a/b, stall_fd, stall_mw, reg_write_m) each valid cycle into a circular buffer.
Supports PC-match or forced trigger, a programmable post-trigger window, and a valid/ready readout port draining oldest entry first.

Parameters:
DW, 32, PC and instruction width
DEPTH, 16, trace entries; power of two, >=4
FLAGW, 8, width of packed hazard/status flag vector
PTRW, $clog2(DEPTH), pointer width (derived)

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  tapped instruction is valid this cycle (not bubble/stall)
pc_i  in  DW  PC of tapped instruction
instr_i  in  DW  tapped instruction word
flags_i  in  FLAGW  packed hazard flags
arm_i  in  1  start capture (honoured only in IDLE)
abort_i  in  1  return to IDLE from any state, discard contents
trig_pc_i  in  DW  trigger PC compare value
trig_en_i  in  1  enable PC-match trigger
trig_force_i  in  1  immediate trigger
post_cnt_i  in  PTRW  entries captured after trigger entry (sampled at arm)
rd_ready_i  in  1  readout consumer ready
rd_valid_o  out  1  readout entry valid
rd_pc_o  out  DW  readout PC
rd_instr_o  out  DW  readout instruction
rd_flags_o  out  FLAGW  readout flags
state_o  out  2  IDLE=0, ARMED=1, POST=2, READOUT=3
count_o  out  PTRW+1  stored entries, saturates at DEPTH
wrapped_o  out  1  oldest entries overwritten during ARMED
done_o  out  1  one-cycle pulse when last entry is drained

Behaviour:
- Reset (async): state IDLE, pointers/count/post counter 0; all outputs 0.
- IDLE: no capture. arm_i -> ARMED next cycle; latches post_cnt_i; clears count, wrapped, pointers.
- ARMED: each valid_i cycle writes {pc,instr,flags} at wr_ptr, wr_ptr++ (wraps mod DEPTH); count++ saturating at DEPTH; write while count==DEPTH sets wrapped_o, overwrites oldest.
- Trigger = trig_force_i | (trig_en_i & valid_i & pc_i==trig_pc_i), evaluated in ARMED only. Trigger-cycle entry is captured if valid_i. Then if latched post_cnt==0 -> READOUT, else -> POST.
- POST: each valid_i write decrements remaining count; write that reaches 0 -> READOUT same edge. Stalled cycles (valid_i=0) don't count.
- READOUT: capture disabled. rd_ptr = wr_ptr - count (mod DEPTH), i.e. oldest entry. rd_valid_o=1 while count>0; rd_* combinationally from storage at rd_ptr. On rd_valid_o & rd_ready_i: rd_ptr++, count--. Last entry consumed -> done_o pulse, IDLE. Entering READOUT with count==0 -> done_o pulse, IDLE next cycle.
- abort_i has priority over all events: IDLE next cycle, count=0, rd_valid_o=0, no done_o.
- arm_i outside IDLE ignored. trig_force_i outside ARMED ignored.
- Post window plus trigger entry exceeding DEPTH overwrites oldest pre-trigger entries (wrapped_o=1).
- rd_valid_o never drops without handshake except on abort_i/rst_i.
- Width rules: pointers modulo DEPTH; count PTRW+1 bits, never exceeds DEPTH.

Decomposition:
- Package riscv_trace_pkg: trace_state_e enum (4 states, 2 bits), trace_entry_t packed struct {pc, instr, flags}, flag bit-position localparams (FWD_A, FWD_B, STALL_FD, STALL_MW, REG_WRITE).
- Sub-module trace_ram: DEPTH x entry storage, synchronous write, asynchronous read; no reset on storage array.

Test Plan:
- Arm, trig_en=1, trig_pc=0x20, post_cnt=2, PCs 0x00,0x04..0x2C every cycle -> READOUT after PC 0x28; count=11, wrapped=0; drains 0x00..0x28 in order, done_o pulses once.
- DEPTH=16, 30 valid PCs before trig_force, post_cnt=0 -> wrapped=1, count=16, first readout is 15th captured PC.
- Post window with valid_i low on alternate cycles -> only valid entries counted; PC sequence contiguous on readout.
- Readout with rd_ready_i toggling 1,0,0,1 -> rd_pc_o/rd_valid_o held stable while ready=0; no entry lost or duplicated.
- abort_i mid-POST and mid-READOUT -> IDLE next cycle, rd_valid_o=0, count=0, no done_o; rst_i asserted mid-ARMED -> all outputs 0 immediately.
- arm_i during READOUT and trig_force_i in IDLE -> ignored; state and count unchanged.
